// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding (common to TX and RX),
// frame geometry and the parity helper.
package uart_pkg;

    // Frame state encoding, shared by the transmitter and receiver.
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } uart_state_e;

    localparam int DATA_BITS = 8;

    // Expected parity bit for a byte: sel = 1 gives ^data, sel = 0 gives ~^data.
    function automatic logic parity_bit(input logic sel, input logic [7:0] data);
        return sel ? ^data : ~^data;
    endfunction

endpackage

// File: rtl/uart_rx_if.sv
// Receiver-side bundle: line input, frame configuration, byte output and flags.
//
// Handshake: data_valid_o is a one-cycle strobe with no back-pressure. In the
// cycle it is high, data_o, parity_err_o and frame_err_o carry the new frame;
// they hold that value until the next strobe. The consumer must take the byte
// in that cycle, since there is no ready.
interface uart_rx_if;
    import uart_pkg::*;

    logic        enable_i;
    logic        rx_i;
    logic        parity_en_i;
    logic        parity_sel_i;
    logic        stop_sel_i;
    logic [7:0]  data_o;
    logic        data_valid_o;
    logic        parity_err_o;
    logic        frame_err_o;
    logic        busy_o;
    uart_state_e state_dbg;

    // Receiver side.
    modport slave (
        input  enable_i, rx_i, parity_en_i, parity_sel_i, stop_sel_i,
        output data_o, data_valid_o, parity_err_o, frame_err_o, busy_o, state_dbg
    );

    // Driver / consumer side.
    modport master (
        output enable_i, rx_i, parity_en_i, parity_sel_i, stop_sel_i,
        input  data_o, data_valid_o, parity_err_o, frame_err_o, busy_o, state_dbg
    );

endinterface

// File: rtl/uart_sync2.sv
// Two-flop synchroniser for a single asynchronous input. The reset value is a
// parameter so idle-high lines do not show a false edge when reset releases.
module uart_sync2 #(
    parameter logic p_reset_val = 1'b1
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;
    logic sync_q;

    // Shift the async input through two flops.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            meta_q <= p_reset_val;
            sync_q <= p_reset_val;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/uart_rx.sv
// UART receiver: 1 start bit, 8 data bits LSB first, optional parity,
// 1 or 2 stop bits. Samples at mid-bit using a cycle counter restarted on the
// start edge. Each byte is delivered as a one-cycle valid strobe together with
// parity and framing error flags.
module uart_rx
    import uart_pkg::*;
#(
    parameter int p_clk_speed_hz = 50_000_000,
    parameter int p_baud_rate    = 9_600
) (
    input  logic      clk_i,
    input  logic      rst_i,
    uart_rx_if.slave  bus
);

    localparam int BIT_CYCLES  = p_clk_speed_hz / p_baud_rate;
    localparam int HALF_CYCLES = BIT_CYCLES / 2;
    localparam int CNT_W       = $clog2(BIT_CYCLES) + 1;

    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(BIT_CYCLES - 1);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF_CYCLES - 1);
    localparam logic [2:0]       LAST_BIT  = 3'(DATA_BITS - 1);

    // Synchronised line and its previous value (for edge detection).
    logic rx_s;
    logic rx_prev_q;

    // FSM state.
    uart_state_e state_q;
    uart_state_e state_d;

    // Bit timing and frame progress.
    logic [CNT_W-1:0] cnt_q;
    logic [2:0]       bit_cnt_q;
    logic             stop_cnt_q;
    logic [7:0]       shift_q;

    // Configuration captured at the start edge; held for the whole frame.
    logic par_en_q;
    logic par_sel_q;
    logic stop2_q;

    // Error accumulators for the frame in progress.
    logic perr_q;
    logic ferr_q;

    // Strobes from the FSM to the datapath.
    logic start_det;
    logic capture;
    logic cnt_clr;
    logic data_sample;
    logic parity_sample;
    logic stop_sample;
    logic frame_done;
    logic bit_tick;
    logic half_tick;

    uart_sync2 #(.p_reset_val(1'b1)) u_sync (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .d_i   (bus.rx_i),
        .q_o   (rx_s)
    );

    // A start needs a high-to-low transition while enabled, so a line that is
    // already low (break, or enable raised mid-low) never starts a frame.
    assign start_det = bus.enable_i && rx_prev_q && !rx_s;
    assign bit_tick  = (cnt_q == BIT_LAST);
    assign half_tick = (cnt_q == HALF_LAST);

    // Remember the previous synchronised line level.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rx_prev_q <= 1'b1;
        end else begin
            rx_prev_q <= rx_s;
        end
    end

    // State register.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic and datapath strobes.
    always_comb begin
        state_d       = state_q;
        capture       = 1'b0;
        cnt_clr       = 1'b0;
        data_sample   = 1'b0;
        parity_sample = 1'b0;
        stop_sample   = 1'b0;
        frame_done    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start_det) begin
                    capture = 1'b1;
                    cnt_clr = 1'b1;
                    state_d = ST_START;
                end
            end
            ST_START: begin
                // Re-check the line half a bit in; a high level was a glitch.
                if (half_tick) begin
                    cnt_clr = 1'b1;
                    state_d = rx_s ? ST_IDLE : ST_DATA;
                end
            end
            ST_DATA: begin
                if (bit_tick) begin
                    cnt_clr     = 1'b1;
                    data_sample = 1'b1;
                    if (bit_cnt_q == LAST_BIT) begin
                        state_d = par_en_q ? ST_PARITY : ST_STOP;
                    end
                end
            end
            ST_PARITY: begin
                if (bit_tick) begin
                    cnt_clr       = 1'b1;
                    parity_sample = 1'b1;
                    state_d       = ST_STOP;
                end
            end
            ST_STOP: begin
                // Leave at mid-stop-bit so a slightly fast sender's next start
                // edge is not missed.
                if (bit_tick) begin
                    cnt_clr     = 1'b1;
                    stop_sample = 1'b1;
                    if (!stop2_q || stop_cnt_q) begin
                        frame_done = 1'b1;
                        state_d    = ST_IDLE;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Bit-period counter: runs in every non-idle state, restarted by the FSM.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else if (cnt_clr) begin
            cnt_q <= '0;
        end else if (state_q != ST_IDLE) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    // Frame capture: configuration, data shift, parity and stop checks.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            par_en_q   <= 1'b0;
            par_sel_q  <= 1'b0;
            stop2_q    <= 1'b0;
            bit_cnt_q  <= '0;
            stop_cnt_q <= 1'b0;
            shift_q    <= '0;
            perr_q     <= 1'b0;
            ferr_q     <= 1'b0;
        end else if (capture) begin
            par_en_q   <= bus.parity_en_i;
            par_sel_q  <= bus.parity_sel_i;
            stop2_q    <= bus.stop_sel_i;
            bit_cnt_q  <= '0;
            stop_cnt_q <= 1'b0;
            perr_q     <= 1'b0;
            ferr_q     <= 1'b0;
        end else if (data_sample) begin
            shift_q[bit_cnt_q] <= rx_s;
            bit_cnt_q          <= bit_cnt_q + 1'b1;
        end else if (parity_sample) begin
            perr_q <= (rx_s != parity_bit(par_sel_q, shift_q));
        end else if (stop_sample) begin
            stop_cnt_q <= 1'b1;
            if (!rx_s) begin
                ferr_q <= 1'b1;
            end
        end
    end

    // Output registers: updated only when a frame completes.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            bus.data_o       <= '0;
            bus.data_valid_o <= 1'b0;
            bus.parity_err_o <= 1'b0;
            bus.frame_err_o  <= 1'b0;
        end else begin
            bus.data_valid_o <= frame_done;
            if (frame_done) begin
                bus.data_o       <= shift_q;
                bus.parity_err_o <= perr_q;
                // The final stop sample is taken in this same cycle.
                bus.frame_err_o  <= ferr_q | !rx_s;
            end
        end
    end

    assign bus.busy_o    = (state_q != ST_IDLE);
    assign bus.state_dbg = state_q;

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx at 16 clocks per bit.
module tb_uart_rx;
    import uart_pkg::*;

    localparam int BIT = 16;

    logic clk = 1'b0;
    logic rst;

    // Clock and reset.
    always #5 clk = ~clk;

    uart_rx_if bus ();

    uart_rx #(
        .p_clk_speed_hz (16),
        .p_baud_rate    (1)
    ) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;
    int pulse_total = 0;

    // Scoreboard: {parity_err, frame_err, data}.
    logic [9:0] exp_q[$];
    logic [9:0] got_q[$];
    logic       busy_q[$];
    logic [1:0] v_hist;

    // Monitor: record each valid pulse, and busy two cycles after it.
    always @(negedge clk) begin
        if (rst) begin
            v_hist <= 2'b00;
        end else begin
            if (v_hist[1]) busy_q.push_back(bus.busy_o);
            if (bus.data_valid_o) begin
                got_q.push_back({bus.parity_err_o, bus.frame_err_o, bus.data_o});
                pulse_total <= pulse_total + 1;
            end
            v_hist <= {v_hist[0], bus.data_valid_o};
        end
    end

    // Watchdog.
    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, checks %0d errors %0d", checks, errors);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive_bit(input logic b);
        bus.rx_i = b;
        repeat (BIT) @(posedge clk);
        #1;
    endtask

    task automatic set_cfg(input logic pen, input logic psel, input logic s2);
        bus.parity_en_i  = pen;
        bus.parity_sel_i = psel;
        bus.stop_sel_i   = s2;
    endtask

    task automatic send_frame(input logic [7:0] d, input logic pen, input logic pbit,
                              input logic stop2, input logic stop2_val);
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(d[i]);
        if (pen) drive_bit(pbit);
        drive_bit(1'b1);
        if (stop2) drive_bit(stop2_val);
    endtask

    task automatic expect_frame(input logic [7:0] d, input logic perr, input logic ferr);
        exp_q.push_back({perr, ferr, d});
    endtask

    task automatic check_frame(input string tag);
        int n;
        logic [9:0] g;
        logic [9:0] e;
        n = 0;
        while ((got_q.size() == 0 || busy_q.size() == 0) && n < 4 * BIT) begin
            @(negedge clk);
            n++;
        end
        if (got_q.size() == 0 || busy_q.size() == 0 || exp_q.size() == 0) begin
            checks++;
            errors++;
            $error("FAIL %s_pulse: observed no pulse expected one", tag);
        end else begin
            g = got_q.pop_front();
            e = exp_q.pop_front();
            chk({tag, "_data"}, 32'(g[7:0]), 32'(e[7:0]));
            chk({tag, "_perr"}, 32'(g[9]), 32'(e[9]));
            chk({tag, "_ferr"}, 32'(g[8]), 32'(e[8]));
            chk({tag, "_busy"}, 32'(busy_q.pop_front()), 32'(0));
        end
    endtask

    // Directed sequence.
    initial begin
        rst              = 1'b1;
        bus.enable_i     = 1'b1;
        bus.rx_i         = 1'b1;
        set_cfg(1'b0, 1'b0, 1'b0);
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_data",  32'(bus.data_o), 32'h00);
        chk("rst_valid", 32'(bus.data_valid_o), 32'(0));
        chk("rst_perr",  32'(bus.parity_err_o), 32'(0));
        chk("rst_ferr",  32'(bus.frame_err_o), 32'(0));
        chk("rst_busy",  32'(bus.busy_o), 32'(0));
        chk("rst_state", 32'(bus.state_dbg), 32'(ST_IDLE));
        @(posedge clk); #1;

        // 0xA5, no parity, one stop bit.
        expect_frame(8'hA5, 1'b0, 1'b0);
        send_frame(8'hA5, 1'b0, 1'b0, 1'b0, 1'b1);
        drive_bit(1'b1);
        check_frame("a5");

        // 0x3C with even-count data, sel=1: correct parity bit is 0.
        set_cfg(1'b1, 1'b1, 1'b0);
        expect_frame(8'h3C, 1'b0, 1'b0);
        send_frame(8'h3C, 1'b1, 1'b0, 1'b0, 1'b1);
        drive_bit(1'b1);
        check_frame("par_ok");
        expect_frame(8'h3C, 1'b1, 1'b0);
        send_frame(8'h3C, 1'b1, 1'b1, 1'b0, 1'b1);
        drive_bit(1'b1);
        check_frame("par_bad");

        // 0x81, two stop bits, second one low.
        set_cfg(1'b0, 1'b0, 1'b1);
        expect_frame(8'h81, 1'b0, 1'b1);
        send_frame(8'h81, 1'b0, 1'b0, 1'b1, 1'b0);
        drive_bit(1'b1);
        check_frame("stop2_low");

        // 5-cycle glitch while idle: false start, no pulse, outputs held.
        set_cfg(1'b0, 1'b0, 1'b0);
        bus.rx_i = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk);
        chk("glitch_busy_hi", 32'(bus.busy_o), 32'(1));
        @(posedge clk); #1;
        bus.rx_i = 1'b1;
        repeat (20) @(posedge clk);
        @(negedge clk);
        chk("glitch_busy_lo", 32'(bus.busy_o), 32'(0));
        repeat (3 * BIT) @(posedge clk);
        @(negedge clk);
        chk("glitch_busy_stay", 32'(bus.busy_o), 32'(0));
        chk("glitch_nopulse",   32'(got_q.size()), 32'(0));
        chk("glitch_data_hold", 32'(bus.data_o), 32'h81);
        chk("glitch_ferr_hold", 32'(bus.frame_err_o), 32'(1));
        @(posedge clk); #1;

        // Back-to-back frames as a transmitter would send them.
        expect_frame(8'h00, 1'b0, 1'b0);
        expect_frame(8'hFF, 1'b0, 1'b0);
        expect_frame(8'h55, 1'b0, 1'b0);
        send_frame(8'h00, 1'b0, 1'b0, 1'b0, 1'b1);
        send_frame(8'hFF, 1'b0, 1'b0, 1'b0, 1'b1);
        send_frame(8'h55, 1'b0, 1'b0, 1'b0, 1'b1);
        drive_bit(1'b1);
        check_frame("loop0");
        check_frame("loop1");
        check_frame("loop2");

        // Break: line held low gives 0x00 with frame error, then no restart.
        expect_frame(8'h00, 1'b0, 1'b1);
        bus.rx_i = 1'b0;
        repeat (12 * BIT) @(posedge clk);
        #1;
        check_frame("break");
        repeat (4 * BIT) @(posedge clk);
        @(negedge clk);
        chk("break_idle",     32'(bus.busy_o), 32'(0));
        chk("break_nopulse",  32'(got_q.size()), 32'(0));
        @(posedge clk); #1;
        drive_bit(1'b1);
        expect_frame(8'h5A, 1'b0, 1'b0);
        send_frame(8'h5A, 1'b0, 1'b0, 1'b0, 1'b1);
        drive_bit(1'b1);
        check_frame("after_break");

        // Disabled: a full frame is ignored.
        bus.enable_i = 1'b0;
        send_frame(8'h77, 1'b0, 1'b0, 1'b0, 1'b1);
        drive_bit(1'b1);
        bus.enable_i = 1'b1;
        drive_bit(1'b1);
        chk("dis_nopulse", 32'(got_q.size()), 32'(0));

        // Enable raised while the line is already low: no start.
        bus.enable_i = 1'b0;
        bus.rx_i = 1'b0;
        repeat (8) @(posedge clk);
        #1 bus.enable_i = 1'b1;
        repeat (6 * BIT) @(posedge clk);
        @(negedge clk);
        chk("en_low_busy", 32'(bus.busy_o), 32'(0));
        @(posedge clk); #1;
        repeat (6 * BIT) @(posedge clk);
        #1;
        drive_bit(1'b1);
        chk("en_low_nopulse", 32'(got_q.size()), 32'(0));

        // Enable dropped mid-frame: the frame still completes.
        expect_frame(8'h96, 1'b0, 1'b0);
        fork
            send_frame(8'h96, 1'b0, 1'b0, 1'b0, 1'b1);
            begin
                repeat (40) @(posedge clk);
                #1 bus.enable_i = 1'b0;
            end
        join
        drive_bit(1'b1);
        check_frame("en_drop");
        bus.enable_i = 1'b1;

        // Reset during data bit 4, then a clean 0x12.
        drive_bit(1'b0);
        for (int i = 0; i < 4; i++) drive_bit(1'b1);
        bus.rx_i = 1'b1;
        repeat (8) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("midrst_state", 32'(bus.state_dbg), 32'(ST_IDLE));
        chk("midrst_busy",  32'(bus.busy_o), 32'(0));
        chk("midrst_data",  32'(bus.data_o), 32'h00);
        chk("midrst_valid", 32'(bus.data_valid_o), 32'(0));
        @(posedge clk); #1 rst = 1'b0;
        drive_bit(1'b1);
        drive_bit(1'b1);
        chk("midrst_nopulse", 32'(got_q.size()), 32'(0));
        expect_frame(8'h12, 1'b0, 1'b0);
        send_frame(8'h12, 1'b0, 1'b0, 1'b0, 1'b1);
        drive_bit(1'b1);
        check_frame("after_rst");
        drive_bit(1'b1);

        chk("pulse_total", 32'(pulse_total), 32'(11));
        chk("no_extra",    32'(got_q.size()), 32'(0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- Serial receiver; the downstream peer of the UART transmitter. Consumes the asynchronous serial line and recovers 8-bit frames: 1 start bit, 8 data bits LSB first, optional parity, 1 or 2 stop bits.
- Frame options and parity convention match the transmitter, so a loopback TX→RX returns the original byte.
- Delivers each byte as a one-cycle valid pulse, with parity and framing error flags.

Parameters:
- p_clk_speed_hz, 50_000_000, system clock frequency in Hz.
- p_baud_rate, 9_600, line bit rate.
- Derived localparam BIT_CYCLES = p_clk_speed_hz / p_baud_rate. Derived HALF_CYCLES = BIT_CYCLES / 2. Counter width = $clog2(BIT_CYCLES) + 1.

Ports:
- clk_i  in  1  system clock; the block uses this one clock only.
- rst_i  in  1  reset, synchronous, active-high.
- enable_i  in  1  high permits detection of a new start bit.
- rx_i  in  1  asynchronous serial line; idle level is high.
- parity_en_i  in  1  1 = a parity bit follows the data bits.
- parity_sel_i  in  1  1 = expected parity bit is ^data; 0 = expected parity bit is ~^data.
- stop_sel_i  in  1  0 = one stop bit; 1 = two stop bits.
- data_o  out  8  last received byte.
- data_valid_o  out  1  one-cycle pulse when data_o and the error flags update.
- parity_err_o  out  1  parity mismatch on the last frame.
- frame_err_o  out  1  a stop bit sampled low on the last frame.
- busy_o  out  1  high whenever the state is not IDLE.

Behaviour:
- Reset (rst_i high at a clk_i edge): state = IDLE, counters = 0, data_o = 0, data_valid_o = 0, parity_err_o = 0, frame_err_o = 0, busy_o = 0. Both synchroniser flops reset to 1.
- Synchroniser: rx_i passes through 2 flops to give rx_s. All decisions use rx_s only.
- IDLE:
  - If enable_i = 1 and rx_s = 0, capture parity_en_i, parity_sel_i and stop_sel_i, clear the cycle counter, and go to START.
  - Configuration changes after capture have no effect on the frame in progress.
- START:
  - The cycle counter counts up to HALF_CYCLES-1. On that cycle, sample rx_s.
  - rx_s = 1: false start. Return to IDLE, no pulse, outputs unchanged.
  - rx_s = 0: clear the counter, bit_cnt = 0, go to DATA.
- DATA:
  - Every BIT_CYCLES cycles (i.e. at the middle of each bit), shift rx_s into shift_reg[bit_cnt] and increment bit_cnt.
  - After the 8th sample: go to PARITY if parity was captured enabled, otherwise go to STOP.
- PARITY:
  - Sample at mid-bit. perr = sampled bit != (sel ? ^shift_reg : ~^shift_reg).
  - Go to STOP.
- STOP:
  - Sample 1 stop bit, or 2 if stop_sel was captured as 1, each at mid-bit. ferr is set if any stop sample is 0.
  - After the final stop sample, in the same cycle:
    - register data_o = shift_reg;
    - parity_err_o = perr (0 if parity disabled);
    - frame_err_o = ferr;
    - data_valid_o = 1 for exactly one cycle;
    - go to IDLE.
  - Returning at mid-stop-bit allows back-to-back frames from a transmitter running slightly fast.
- Output holding: data_o and the error flags hold their values until the next valid pulse. A frame with errors still pulses data_valid_o.
- Break condition (line held low): delivers data 0x00 with frame_err_o = 1. The block then waits in IDLE until rx_s returns high before accepting a new start bit.
- enable_i:
  - Deasserting it mid-frame does not abort the frame.
  - Asserting it while rx_s is already low does not start a frame. A start requires a high-to-low transition seen while enabled, so the block tracks the previous rx_s.
- Reset mid-frame: the next cycle is IDLE with all outputs at reset values. No pulse is produced for the aborted frame.
- Latency: the valid pulse occurs 2 (synchroniser) + HALF_CYCLES + (8 + p + s)·BIT_CYCLES cycles after the rx_i falling edge, ±1 cycle. p = 1 if parity enabled, else 0; s = number of stop bits.
- Sampling tolerance: a baud mismatch of up to ±3 % must decode correctly.

Decomposition:
- Shared package uart_pkg holds:
  - state encodings (IDLE, START, DATA, PARITY, STOP; 3 bits), shared with the transmitter;
  - the parity helper function (sel, byte) → expected bit.
- One sub-module: uart_sync2, a 2-flop synchroniser with a reset value parameter. It is reusable on other async inputs.

Test Plan (p_clk_speed_hz=16, p_baud_rate=1, so BIT_CYCLES=16):
- Byte 0xA5, no parity, 1 stop, driven by the bench → one data_valid_o pulse, data_o = 0xA5, both error flags 0, busy_o low within 2 cycles after the pulse.
- 0x3C with parity_en=1, parity_sel=1, correct parity bit 0 → parity_err_o = 0. Repeat with the parity bit flipped → parity_err_o = 1, data_o = 0x3C.
- 0x81 with stop_sel=1, second stop bit driven low → data_o = 0x81, frame_err_o = 1.
- 5-cycle low glitch on rx_i while idle → no pulse, busy_o returns to 0 and stays there, data_o unchanged.
- Loopback from uart_tx running at the same parameters, bytes 0x00, 0xFF, 0x55 back to back → 3 pulses in order with matching data and no errors.
- rst_i asserted during data bit 4, then 0x12 sent → no pulse for the aborted frame, then exactly one pulse with data_o = 0x12.
